axi_rd_slave: RTL and testbench



---
 rtl/axi_rd_slave.sv | 203 ++++++++++++++++++++
 tb/tb_axi_rd_slave.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_slave.sv
// axi_rd_slave: AXI read slave (AR/R channels) returning SEED ^ beat-address pattern data.
// Optional feature macro AXI_RD_SLV_ERR_EN: beats at or beyond MEM_BYTES return SLVERR with zero data.
module axi_rd_slave #(
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MEM_BYTES = 4096,
  parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] ARID,
  input  logic [31:0]     ARADDR,
  input  logic [7:0]      ARLEN,
  input  logic [2:0]      ARSIZE,
  input  logic [1:0]      ARBURST,
  input  logic            ARVALID,
  output logic            ARREADY,
  output logic [ID_W-1:0] RID,
  output logic [31:0]     RDATA,
  output logic [1:0]      RRESP,
  output logic            RLAST,
  output logic            RVALID,
  input  logic            RREADY,
  output logic [3:0]      RSTRB
);

  localparam logic [31:0] MEM_MASK = 32'(MEM_BYTES - 1);

  typedef enum logic {IDLE, BURST} state_e;
  typedef enum logic [1:0] {K_FIXED, K_INCR, K_WRAP} kind_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [1:0]      size;
    kind_e           kind;
  } req_t;

  state_e          state_q, state_d;
  req_t            cur_q, cur_d, pend_q, pend_d, new_req_c, load_req;
  logic            pend_valid_q, pend_valid_d;
  logic [7:0]      beat_q, beat_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            rlast_q, rlast_d;
  logic [3:0]      rstrb_q, rstrb_d;
  logic            ar_hs, r_hs, last_hs, load, advance, oob;

  assign ar_hs   = ARVALID & arready_q;
  assign r_hs    = rvalid_q & RREADY;
  assign last_hs = r_hs & rlast_q;

  // Address following the current beat; WRAP keeps the low bits inside the aligned container.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [1:0] size, input kind_e kind);
    logic [31:0] nb, incr, cont_mask;
    nb        = 32'd1 << size;
    incr      = (addr & ~(nb - 32'd1)) + nb;
    cont_mask = ((32'(len) + 32'd1) << size) - 32'd1;
    case (kind)
      K_FIXED: next_addr = addr;
      K_WRAP:  next_addr = (addr & ~cont_mask) | (incr & cont_mask);
      default: next_addr = incr;
    endcase
  endfunction

  // Normalise the incoming request: clamp size, fold reserved/illegal bursts into INCR.
  always_comb begin
    new_req_c.id   = ARID;
    new_req_c.addr = ARADDR;
    new_req_c.len  = ARLEN;
    new_req_c.size = (ARSIZE > 3'd2) ? 2'd2 : ARSIZE[1:0];
    if (ARBURST == 2'b00)
      new_req_c.kind = K_FIXED;
    else if (ARBURST == 2'b10 &&
             (ARLEN == 8'd1 || ARLEN == 8'd3 || ARLEN == 8'd7 || ARLEN == 8'd15))
      new_req_c.kind = K_WRAP;
    else
      new_req_c.kind = K_INCR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_hs) state_d = BURST;
      default: if (last_hs && !pend_valid_q && !ar_hs) state_d = IDLE;
    endcase
  end

  // Engine, pending slot and registered R-channel outputs.
  always_comb begin
    cur_d        = cur_q;
    beat_d       = beat_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    rvalid_d     = rvalid_q;
    rid_d        = rid_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    rlast_d      = rlast_q;
    rstrb_d      = rstrb_q;
    load         = 1'b0;
    advance      = 1'b0;
    load_req     = new_req_c;
    oob          = 1'b0;

    if (state_q == IDLE) begin
      load = ar_hs;
    end else if (last_hs) begin
      if (pend_valid_q) begin
        load         = 1'b1;
        load_req     = pend_q;
        pend_valid_d = ar_hs;
        pend_d       = new_req_c;
      end else if (ar_hs) begin
        load = 1'b1;
      end else begin
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
      end
    end else begin
      if (ar_hs) begin
        pend_valid_d = 1'b1;
        pend_d       = new_req_c;
      end
      advance = r_hs;
    end

    if (load) begin
      cur_d   = load_req;
      beat_d  = 8'd0;
      rlast_d = (load_req.len == 8'd0);
    end else if (advance) begin
      cur_d.addr = next_addr(cur_q.addr, cur_q.len, cur_q.size, cur_q.kind);
      beat_d     = beat_q + 8'd1;
      rlast_d    = ((beat_q + 8'd1) == cur_q.len);
    end

    if (load || advance) begin
`ifdef AXI_RD_SLV_ERR_EN
      oob = (cur_d.addr & ~MEM_MASK) != 32'd0;
`else
      oob = 1'b0;
`endif
      rvalid_d = 1'b1;
      rid_d    = cur_d.id;
      rdata_d  = oob ? 32'd0 : (((cur_d.addr & MEM_MASK) & 32'hFFFF_FFFC) ^ SEED);
      rresp_d  = oob ? 2'b10 : 2'b00;
      case (cur_d.size)
        2'd0:    rstrb_d = 4'b0001 << cur_d.addr[1:0];
        2'd1:    rstrb_d = 4'b0011 << {cur_d.addr[1], 1'b0};
        default: rstrb_d = 4'hF;
      endcase
    end

    arready_d = !pend_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q        <= '0;
      beat_q       <= 8'd0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rid_q        <= '0;
      rdata_q      <= 32'd0;
      rresp_q      <= 2'b00;
      rlast_q      <= 1'b0;
      rstrb_q      <= 4'd0;
    end else begin
      cur_q        <= cur_d;
      beat_q       <= beat_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rid_q        <= rid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      rlast_q      <= rlast_d;
      rstrb_q      <= rstrb_d;
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;
  assign RSTRB   = rstrb_q;

endmodule

// File: tb/tb_axi_rd_slave.sv
// tb_axi_rd_slave: directed stimulus for axi_rd_slave with a queue-based burst model checked every cycle.
`timescale 1ns/1ps
module tb_axi_rd_slave;

  localparam int unsigned ID_W      = 4;
  localparam int unsigned MEM_BYTES = 4096;
  localparam logic [31:0] SEED      = 32'hA5A5_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  logic [3:0]      rstrb;

  always #5 clk = ~clk;

  axi_rd_slave #(.ID_W(ID_W), .MEM_BYTES(MEM_BYTES), .SEED(SEED)) dut (
    .clk(clk), .rst(rst),
    .ARID(arid), .ARADDR(araddr), .ARLEN(arlen), .ARSIZE(arsize), .ARBURST(arburst),
    .ARVALID(arvalid), .ARREADY(arready),
    .RID(rid), .RDATA(rdata), .RRESP(rresp), .RLAST(rlast), .RVALID(rvalid),
    .RREADY(rready), .RSTRB(rstrb)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    int unsigned len;
    int unsigned size;
    logic [1:0]  burst;
  } breq_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  strb;
  } beat_t;

  breq_t       q[$];
  beat_t       log_q[$];
  int unsigned beat_n = 0;
  logic        arready_exp = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Beat address from burst rules: n-th beat of the request.
  function automatic logic [31:0] m_addr(input breq_t r, input int unsigned n);
    int unsigned s;
    logic [31:0] nb, al, cont, base;
    bit          wrap;
    s    = (r.size > 2) ? 2 : r.size;
    nb   = 32'd1 << s;
    wrap = (r.burst == 2'b10) && (r.len == 1 || r.len == 3 || r.len == 7 || r.len == 15);
    if (n == 0 || r.burst == 2'b00) return r.addr;
    al = r.addr - (r.addr % nb);
    if (!wrap) return al + nb * n;
    cont = nb * (r.len + 1);
    base = r.addr - (r.addr % cont);
    return base + ((al - base + nb * n) % cont);
  endfunction

  function automatic beat_t m_beat(input breq_t r, input int unsigned n);
    beat_t       b;
    logic [31:0] a;
    int unsigned s;
    a      = m_addr(r, n);
    s      = (r.size > 2) ? 2 : r.size;
    b.id   = r.id;
    b.last = (n == r.len);
    if (s == 0)      b.strb = 4'b0001 << a[1:0];
    else if (s == 1) b.strb = a[1] ? 4'b1100 : 4'b0011;
    else             b.strb = 4'hF;
`ifdef AXI_RD_SLV_ERR_EN
    b.resp = (a >= MEM_BYTES) ? 2'b10 : 2'b00;
    b.data = (a >= MEM_BYTES) ? 32'd0 : ((a - a % 4) ^ SEED);
`else
    b.resp = 2'b00;
    b.data = ((a % MEM_BYTES) - (a % 4)) ^ SEED;
`endif
    return b;
  endfunction

  // Compare DUT against the model each negedge, then advance the model by the handshakes of the coming edge.
  always @(negedge clk) begin
    beat_t e;
    beat_t got;
    breq_t nr;
    if (rst) begin
      q.delete();
      beat_n      = 0;
      arready_exp = 1'b0;
      chk("rst_arready", 32'(arready), 32'd0);
      chk("rst_rvalid",  32'(rvalid),  32'd0);
      chk("rst_rlast",   32'(rlast),   32'd0);
      chk("rst_rid",     32'(rid),     32'd0);
      chk("rst_rdata",   rdata,        32'd0);
      chk("rst_rresp",   32'(rresp),   32'd0);
      chk("rst_rstrb",   32'(rstrb),   32'd0);
    end else begin
      chk("arready", 32'(arready), 32'(arready_exp));
      chk("rvalid", 32'(rvalid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        e = m_beat(q[0], beat_n);
        chk("rid",   32'(rid),   32'(e.id));
        chk("rdata", rdata,      e.data);
        chk("rresp", 32'(rresp), 32'(e.resp));
        chk("rlast", 32'(rlast), 32'(e.last));
        chk("rstrb", 32'(rstrb), 32'(e.strb));
      end
      if (rvalid && rready) begin
        got.id = rid; got.data = rdata; got.resp = rresp; got.last = rlast; got.strb = rstrb;
        log_q.push_back(got);
        if (q.size() > 0) begin
          if (beat_n == q[0].len) begin
            void'(q.pop_front());
            beat_n = 0;
          end else begin
            beat_n++;
          end
        end
      end
      if (arvalid && arready) begin
        nr.id = arid; nr.addr = araddr; nr.len = 32'(arlen); nr.size = 32'(arsize); nr.burst = arburst;
        q.push_back(nr);
      end
      arready_exp = (q.size() <= 1);
    end
  end

  task automatic issue_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] b, output int waits);
    bit hs = 1'b0;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = b; arvalid = 1'b1;
    waits = 0;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk);
      #1;
      if (!hs) waits++;
    end
    arvalid = 1'b0;
    if (!hs) begin
      n_cmp++; n_fail++;
      $display("FAIL ar_timeout: ARREADY never high for id %0d", id);
    end
  endtask

  task automatic wait_drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!rvalid) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain: RVALID still high after %0d cycles", budget);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string nm, input int i, input logic [3:0] id, input logic [31:0] data,
                          input logic [1:0] resp, input logic last, input logic [3:0] strb);
    if (i >= log_q.size()) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: beat %0d missing, got %0d beats want more", nm, i, log_q.size());
    end else begin
      chk({nm, "_data"}, log_q[i].data, data);
      chk({nm, "_ctl"}, 32'({log_q[i].id, log_q[i].resp, log_q[i].last, log_q[i].strb}),
          32'({id, resp, last, strb}));
    end
  endtask

  initial begin
    int w;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // INCR word burst
    log_q.delete();
    issue_ar(4'd5, 32'h10, 8'd3, 3'd2, 2'b01, w);
    wait_drain(50);
    chk("t1_count", 32'(log_q.size()), 32'd4);
    chk_beat("t1_b0", 0, 4'd5, 32'hA5A5_0010, 2'b00, 1'b0, 4'hF);
    chk_beat("t1_b1", 1, 4'd5, 32'hA5A5_0014, 2'b00, 1'b0, 4'hF);
    chk_beat("t1_b2", 2, 4'd5, 32'hA5A5_0018, 2'b00, 1'b0, 4'hF);
    chk_beat("t1_b3", 3, 4'd5, 32'hA5A5_001C, 2'b00, 1'b1, 4'hF);

    // WRAP inside a 16-byte container
    log_q.delete();
    issue_ar(4'd2, 32'h38, 8'd3, 3'd2, 2'b10, w);
    wait_drain(50);
    chk_beat("t2_b0", 0, 4'd2, 32'hA5A5_0038, 2'b00, 1'b0, 4'hF);
    chk_beat("t2_b1", 1, 4'd2, 32'hA5A5_003C, 2'b00, 1'b0, 4'hF);
    chk_beat("t2_b2", 2, 4'd2, 32'hA5A5_0030, 2'b00, 1'b0, 4'hF);
    chk_beat("t2_b3", 3, 4'd2, 32'hA5A5_0034, 2'b00, 1'b1, 4'hF);

    // FIXED byte burst at an unaligned address
    log_q.delete();
    issue_ar(4'd4, 32'h41, 8'd2, 3'd0, 2'b00, w);
    wait_drain(50);
    chk_beat("t3_b0", 0, 4'd4, 32'hA5A5_0040, 2'b00, 1'b0, 4'b0010);
    chk_beat("t3_b1", 1, 4'd4, 32'hA5A5_0040, 2'b00, 1'b0, 4'b0010);
    chk_beat("t3_b2", 2, 4'd4, 32'hA5A5_0040, 2'b00, 1'b1, 4'b0010);

    // Illegal WRAP length and oversize ARSIZE fall back to INCR words
    log_q.delete();
    issue_ar(4'd8, 32'h3E, 8'd2, 3'd5, 2'b10, w);
    wait_drain(50);
    chk_beat("t3b_b0", 0, 4'd8, 32'hA5A5_003C, 2'b00, 1'b0, 4'hF);
    chk_beat("t3b_b1", 1, 4'd8, 32'hA5A5_0040, 2'b00, 1'b0, 4'hF);
    chk_beat("t3b_b2", 2, 4'd8, 32'hA5A5_0044, 2'b00, 1'b1, 4'hF);

    // Backpressure on beat index 2 of an 8-beat INCR
    log_q.delete();
    issue_ar(4'd7, 32'h100, 8'd7, 3'd2, 2'b01, w);
    for (int i = 0; i < 20 && log_q.size() < 2; i++) begin
      @(posedge clk);
      #1;
    end
    rready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_hold_rdata", rdata, 32'hA5A5_0108);
      chk("t4_hold_rlast", 32'(rlast), 32'd0);
    end
    @(posedge clk);
    #1 rready = 1'b1;
    wait_drain(50);
    chk("t4_count", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk_beat("t4_b", i, 4'd7, 32'hA5A5_0100 + 32'(4 * i), 2'b00, (i == 7), 4'hF);

    // Burst crossing the top of the window
    log_q.delete();
    issue_ar(4'd6, 32'(MEM_BYTES - 4), 8'd1, 3'd2, 2'b01, w);
    wait_drain(50);
    chk_beat("t6_b0", 0, 4'd6, 32'hA5A5_0FFC, 2'b00, 1'b0, 4'hF);
`ifdef AXI_RD_SLV_ERR_EN
    chk_beat("t6_b1", 1, 4'd6, 32'h0000_0000, 2'b10, 1'b1, 4'hF);
`else
    chk_beat("t6_b1", 1, 4'd6, 32'hA5A5_0000, 2'b00, 1'b1, 4'hF);
`endif

    // Three back-to-back requests, then reset in the middle of the second burst
    log_q.delete();
    issue_ar(4'd1, 32'h200, 8'd1, 3'd2, 2'b01, w);
    chk("t5_wait1", 32'(w), 32'd0);
    issue_ar(4'd2, 32'h300, 8'd1, 3'd2, 2'b01, w);
    chk("t5_wait2", 32'(w), 32'd0);
    issue_ar(4'd3, 32'h400, 8'd1, 3'd2, 2'b01, w);
    chk("t5_wait3", 32'(w), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_rvalid",  32'(rvalid),  32'd0);
    chk("t5_rst_arready", 32'(arready), 32'd0);
    chk("t5_rst_rid",     32'(rid),     32'd0);
    chk("t5_rst_rdata",   rdata,        32'd0);
    chk("t5_rst_rlast",   32'(rlast),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("t5_count", 32'(log_q.size()), 32'd3);
    chk_beat("t5_b0", 0, 4'd1, 32'hA5A5_0200, 2'b00, 1'b0, 4'hF);
    chk_beat("t5_b1", 1, 4'd1, 32'hA5A5_0204, 2'b00, 1'b1, 4'hF);
    chk_beat("t5_b2", 2, 4'd2, 32'hA5A5_0300, 2'b00, 1'b0, 4'hF);
    repeat (3) @(posedge clk);
    #1;

    // Recovery after reset: halfword INCR from an odd address, reserved burst type
    log_q.delete();
    issue_ar(4'd9, 32'h3, 8'd2, 3'd1, 2'b11, w);
    wait_drain(50);
    chk_beat("t7_b0", 0, 4'd9, 32'hA5A5_0000, 2'b00, 1'b0, 4'b1100);
    chk_beat("t7_b1", 1, 4'd9, 32'hA5A5_0004, 2'b00, 1'b0, 4'b0011);
    chk_beat("t7_b2", 2, 4'd9, 32'hA5A5_0004, 2'b00, 1'b1, 4'b1100);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: bench did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

endmodule
